// File: rtl/byte_skid_buffer.sv
// byte_skid_buffer: two-entry valid/ready slice with registered outputs.
// Optional BYTE_SKID_BUFFER_STATS_EN adds a 16-bit output handshake counter.
module byte_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef BYTE_SKID_BUFFER_STATS_EN
  output logic [WIDTH-1:0] m_data,
  output logic [15:0]      xfer_count
`else
  output logic [WIDTH-1:0] m_data
`endif
);

  // bit0 = m_valid, bit1 = full; outputs are raw flop bits
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_hs;
  logic             out_hs;

  assign m_valid = state_q[0];
  assign s_ready = ~state_q[1];
  assign m_data  = main_q;

  assign in_hs  = s_valid & s_ready;
  assign out_hs = m_valid & m_ready;

  // next-state and storage steering
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_hs) begin
          main_d  = s_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_hs && out_hs) begin
          main_d = s_data;
        end else if (in_hs) begin
          skid_d  = s_data;
          state_d = TWO;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_hs) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // state and data registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef BYTE_SKID_BUFFER_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d      = out_hs ? cnt_q + 16'd1 : cnt_q;
  assign xfer_count = cnt_q;

  // output handshake counter, wraps naturally
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_byte_skid_buffer.sv
// tb_byte_skid_buffer: vector table, directed corners and
// random stalls against a queue model.
module tb_byte_skid_buffer;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef BYTE_SKID_BUFFER_STATS_EN
  logic [15:0] xfer_count;
`endif

  always #5 clk = ~clk;

  byte_skid_buffer #(.WIDTH(8)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef BYTE_SKID_BUFFER_STATS_EN
    .m_data     (m_data),
    .xfer_count (xfer_count)
`else
    .m_data     (m_data)
`endif
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: a FIFO of depth two; m_data shows the
  // head, or the last head once the FIFO drains
  logic [7:0] mq[$];
  logic [7:0] mshow;
  int         mcnt;

  task automatic model_reset();
    mq.delete();
    mshow = 8'h00;
    mcnt  = 0;
  endtask

  task automatic model_edge(input bit sv,
                            input logic [7:0] sd,
                            input bit mr);
    bit o;
    bit i;
    o = (mq.size() > 0) && mr;
    i = sv && (mq.size() < 2);
    if (o) begin
      void'(mq.pop_front());
      mcnt++;
    end
    if (i) mq.push_back(sd);
    if (mq.size() > 0) mshow = mq[0];
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".m_valid"}, m_valid, mq.size() > 0);
    chk({tag, ".s_ready"}, s_ready, mq.size() < 2);
    chk({tag, ".m_data"}, m_data, mshow);
`ifdef BYTE_SKID_BUFFER_STATS_EN
    chk({tag, ".xfer"}, xfer_count, mcnt & 32'hFFFF);
`endif
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    m_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         sv;
    logic [7:0] sd;
    bit         mr;
    bit         mv;
    bit         sr;
    logic [7:0] md;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit sv, logic [7:0] sd, bit mr,
                              bit mv, bit sr, logic [7:0] md);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr;
    v.mv = mv; v.sr = sr; v.md = md;
    return v;
  endfunction

  initial begin
    logic [7:0] nxt;
    logic [7:0] expo;
    logic [7:0] pre_md;
    bit         stall;
    bit         sv_r;
    bit         mr_r;
    bit         o_m;
    bit         i_m;

    // backpressure: A5, 5A fill; FF refused; drain; FF again
    vt.push_back(mk(1, 8'hA5, 0, 1, 1, 8'hA5));
    vt.push_back(mk(1, 8'h5A, 0, 1, 0, 8'hA5));
    vt.push_back(mk(1, 8'hFF, 0, 1, 0, 8'hA5));
    vt.push_back(mk(0, 8'h00, 1, 1, 1, 8'h5A));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h5A));
    vt.push_back(mk(1, 8'hFF, 0, 1, 1, 8'hFF));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'hFF));
    // streaming 01..10 with m_ready held high
    for (int i = 1; i <= 16; i++)
      vt.push_back(mk(1, 8'(i), 1, 1, 1, 8'(i)));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h10));

    // reset held with random inputs
    areset_n = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    m_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst.m_valid", m_valid, 0);
      chk("rst.s_ready", s_ready, 1);
      chk("rst.m_data", m_data, 8'h00);
    end
    @(negedge clk);
    areset_n = 1'b1;
    s_valid  = 1'b0;

    // vector table
    foreach (vt[i]) begin
      @(negedge clk);
      s_valid = vt[i].sv;
      s_data  = vt[i].sd;
      m_ready = vt[i].mr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.m_valid", i), m_valid, vt[i].mv);
      chk($sformatf("vec%0d.s_ready", i), s_ready, vt[i].sr);
      chk($sformatf("vec%0d.m_data", i), m_data, vt[i].md);
    end

    // reset asserted between edges clears outputs at once
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h77;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("async.pre_m_data", m_data, 8'h77);
    #2;
    areset_n = 1'b0;
    #1;
    chk("async.m_valid", m_valid, 0);
    chk("async.s_ready", s_ready, 1);
    chk("async.m_data", m_data, 8'h00);
    @(negedge clk);
    areset_n = 1'b1;
    s_valid  = 1'b0;

    // reset while full, then 33 must be first out
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h11;
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_data = 8'h22;
    @(posedge clk);
    #1;
    chk("mid.full_s_ready", s_ready, 0);
    chk("mid.full_m_data", m_data, 8'h11);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    areset_n = 1'b0;
    #1;
    chk("mid.rst_m_valid", m_valid, 0);
    chk("mid.rst_s_ready", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'h33;
    @(posedge clk);
    #1;
    chk("mid.first_m_data", m_data, 8'h33);
    chk("mid.first_m_valid", m_valid, 1);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.drain_m_valid", m_valid, 0);
    chk("mid.drain_m_data", m_data, 8'h33);

    // random stalls against the queue model
    do_reset();
    nxt  = 8'h00;
    expo = 8'h00;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      sv_r    = 1'($urandom_range(0, 1));
      mr_r    = 1'($urandom_range(0, 3) != 0);
      s_valid = sv_r;
      s_data  = nxt;
      m_ready = mr_r;
      #1;
      o_m    = (mq.size() > 0) && mr_r;
      i_m    = sv_r && (mq.size() < 2);
      stall  = m_valid && !m_ready;
      pre_md = m_data;
      if (o_m) begin
        chk("rnd.order", m_data, expo);
        expo++;
      end
      model_edge(sv_r, nxt, mr_r);
      if (i_m) nxt++;
      @(posedge clk);
      #1;
      check_model("rnd");
      if (stall) chk("rnd.stable", m_data, pre_md);
    end

`ifdef BYTE_SKID_BUFFER_STATS_EN
    // 65537 outputs: counter wraps and lands on 1
    do_reset();
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h5C;
    m_ready = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    chk("stats.wrap", xfer_count, 16'h0000);
    @(posedge clk);
    #1;
    chk("stats.one", xfer_count, 16'h0001);
    @(negedge clk);
    areset_n = 1'b0;
    #1;
    chk("stats.rst", xfer_count, 16'h0000);
    @(negedge clk);
    areset_n = 1'b1;
    s_valid  = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
